// File: rtl/edulent_pkg.sv
// Shared types and constants for the output-port UART transmitter.
package edulent_pkg;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/edulent_sync_fifo.sv
// Fall-through synchronous FIFO: o_rdata shows the head before it is popped.
module edulent_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             wr_en, rd_en;

  // A push into a full FIFO is still accepted when a pop frees the slot this cycle.
  assign wr_en   = i_push && (!o_full || i_pop);
  assign rd_en   = i_pop && !o_empty;
  assign o_empty = (wptr == rptr);
  assign o_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign o_rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= i_wdata;
  end
endmodule

// File: rtl/edulent_out_uart_tx.sv
// Captures bytes written to the CPU output port and sends each one as an 8N1 UART frame.
module edulent_out_uart_tx
  import edulent_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 100000000,
  parameter int BAUD          = 115200,
  parameter int FIFO_DEPTH    = 8,
  parameter int CHANGE_DETECT = 1
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  input  logic       i_clr_overflow,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_fifo_full,
  output logic       o_overflow
);
  localparam int CPB = CLK_FREQ_HZ / BAUD;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BW  = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(CPB - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(UART_DATA_BITS - 1);

  if (CPB < 2) begin : g_bad_baud
    $error("CLK_FREQ_HZ / BAUD must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  tx_state_t                  state, state_n;
  logic [CW-1:0]              baud_cnt, baud_cnt_n;
  logic [BW-1:0]              bit_cnt, bit_cnt_n;
  logic [UART_DATA_BITS-1:0]  shift, shift_n, head, last_data;
  logic                       capture, pop, drop, fifo_empty, fifo_full;
  logic                       tx_n, busy_n;

  assign capture = i_valid || ((CHANGE_DETECT != 0) && (i_data != last_data));
  assign drop    = capture && fifo_full && !pop;
  assign o_fifo_full = fifo_full;

  edulent_sync_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (capture),
    .i_pop   (pop),
    .i_wdata (i_data),
    .o_rdata (head),
    .o_empty (fifo_empty),
    .o_full  (fifo_full)
  );

  // State, datapath and output registers; a drop beats a simultaneous clear.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      last_data  <= '0;
      o_overflow <= 1'b0;
      o_tx       <= 1'b1;
      o_busy     <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      o_tx     <= tx_n;
      o_busy   <= busy_n;
      if (capture)             last_data  <= i_data;
      if (drop)                o_overflow <= 1'b1;
      else if (i_clr_overflow) o_overflow <= 1'b0;
    end
  end

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt + 1'b1;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = head;
          state_n = START;
        end
      end
      START: if (baud_cnt == CNT_MAX) begin
        baud_cnt_n = '0;
        bit_cnt_n  = '0;
        state_n    = DATA;
      end
      DATA: if (baud_cnt == CNT_MAX) begin
        baud_cnt_n = '0;
        shift_n    = shift >> 1;
        if (bit_cnt == BIT_MAX) state_n = STOP;
        else                    bit_cnt_n = bit_cnt + 1'b1;
      end
      STOP: if (baud_cnt == CNT_MAX) begin
        baud_cnt_n = '0;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // The line level is computed from the next state so o_tx lands on the same edge as the state.
  always_comb begin
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
    busy_n = (state != IDLE) || !fifo_empty;
  end
endmodule

// File: tb/tb_edulent_out_uart_tx.sv
// Directed bench with a UART monitor scoreboard for edulent_out_uart_tx (CLKS_PER_BIT=4, depth 4).
module tb_edulent_out_uart_tx;
  logic       clk = 1'b0, rstn = 1'b0, valid = 1'b0, clr = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx, busy, full, ovf;
  logic       tx_nc, busy_nc, full_nc, ovf_nc;
  int         n_tests = 0, n_fail = 0, nc_lows = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  edulent_out_uart_tx #(.CLK_FREQ_HZ(16), .BAUD(4), .FIFO_DEPTH(4), .CHANGE_DETECT(1)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_data(data), .i_valid(valid), .i_clr_overflow(clr),
    .o_tx(tx), .o_busy(busy), .o_fifo_full(full), .o_overflow(ovf));

  edulent_out_uart_tx #(.CLK_FREQ_HZ(16), .BAUD(4), .FIFO_DEPTH(4), .CHANGE_DETECT(0)) dut_nc (
    .i_clk(clk), .i_rstn(rstn), .i_data(data), .i_valid(valid), .i_clr_overflow(clr),
    .o_tx(tx_nc), .o_busy(busy_nc), .o_fifo_full(full_nc), .o_overflow(ovf_nc));

  always @(posedge clk) if (tx_nc === 1'b0) nc_lows <= nc_lows + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstn = 1'b0; valid = 1'b0; clr = 1'b0; data = 8'h00;
    cyc; cyc;
    rstn = 1'b1;
    cyc;
  endtask

  task automatic wait_start(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tx === 1'b0) begin ok = 1'b1; break; end
      cyc;
    end
    if (!ok) chk({tag, "_start_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 1000; i++) begin
      if (exp_q.size() == 0 && busy === 1'b0) break;
      cyc;
    end
    chk({tag, "_drain"}, exp_q.size(), 32'd0);
    chk({tag, "_idle"}, busy, 32'd0);
  endtask

  // Frame decoder: samples mid-bit, abandons a frame cut short by reset.
  always begin : mon
    logic [7:0] b;
    bit ab;
    b = 8'h00;
    @(negedge tx);
    repeat (2) @(posedge clk);
    #1;
    ab = !rstn;
    if (!ab) begin
      chk("rx_start", tx, 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(posedge clk);
        #1;
        if (!rstn) begin ab = 1'b1; break; end
        b[i] = tx;
      end
    end
    if (!ab) begin
      repeat (4) @(posedge clk);
      #1;
      if (rstn) begin
        chk("rx_stop", tx, 32'd1);
        if (exp_q.size() == 0) chk("rx_unexpected", {24'd0, b}, 32'hFFFF_FFFF);
        else                   chk("rx_byte", b, exp_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base, n;
    // reset state
    do_reset;
    chk("rst_tx", tx, 32'd1);
    chk("rst_busy", busy, 32'd0);
    chk("rst_full", full, 32'd0);
    chk("rst_ovf", ovf, 32'd0);

    // 1: single byte, exact latency
    data = 8'hA5; valid = 1'b1; exp_q.push_back(8'hA5);
    cyc;
    valid = 1'b0;
    chk("t1_tx_n1", tx, 32'd1);
    cyc;
    chk("t1_tx_n2", tx, 32'd0);
    chk("t1_busy", busy, 32'd1);
    drain("t1");

    // 2: change detect, then no-change-detect instance must stay silent
    do_reset;
    base = nc_lows;
    data = 8'h3C; exp_q.push_back(8'h3C);
    cyc; cyc;
    data = 8'h81; exp_q.push_back(8'h81);
    cyc;
    drain("t2");
    repeat (10) cyc;
    chk("t2_no_extra", busy, 32'd0);
    chk("t2_nc_silent", nc_lows - base, 32'd0);
    chk("t2_nc_busy", busy_nc, 32'd0);

    // 3: overflow on the sixth push
    do_reset;
    for (int k = 1; k <= 6; k++) begin
      data = 8'(k); valid = 1'b1;
      if (k <= 5) exp_q.push_back(8'(k));
      cyc;
    end
    valid = 1'b0;
    chk("t3_full", full, 32'd1);
    chk("t3_ovf_set", ovf, 32'd1);
    clr = 1'b1;
    cyc;
    clr = 1'b0;
    chk("t3_ovf_clr", ovf, 32'd0);
    drain("t3");

    // 4: back-to-back frames, stop bit stretched by the IDLE cycle
    do_reset;
    data = 8'hFF; valid = 1'b1; exp_q.push_back(8'hFF);
    cyc;
    data = 8'h00; exp_q.push_back(8'h00);
    cyc;
    valid = 1'b0;
    wait_start("t4");
    repeat (36) cyc;
    n = 0;
    while (tx === 1'b1 && n < 10) begin n++; cyc; end
    chk("t4_stop_len", n, 32'd5);
    chk("t4_second_start", tx, 32'd0);
    drain("t4");

    // 5: reset during DATA bit 3
    do_reset;
    data = 8'h30; valid = 1'b1;
    cyc;
    valid = 1'b0;
    wait_start("t5");
    repeat (17) cyc;
    chk("t5_bit3", tx, 32'd0);
    rstn = 1'b0; data = 8'h00;
    #1;
    chk("t5_rst_tx", tx, 32'd1);
    chk("t5_rst_busy", busy, 32'd0);
    chk("t5_rst_full", full, 32'd0);
    cyc; cyc;
    rstn = 1'b1;
    cyc;
    data = 8'h5A; valid = 1'b1; exp_q.push_back(8'h5A);
    cyc;
    valid = 1'b0;
    drain("t5");

    // 6: drop and clear in the same cycle, set wins
    do_reset;
    for (int k = 0; k < 5; k++) begin
      data = 8'h11 + 8'(k); valid = 1'b1; exp_q.push_back(8'h11 + 8'(k));
      cyc;
    end
    chk("t6_full", full, 32'd1);
    data = 8'h66; clr = 1'b1;
    cyc;
    valid = 1'b0; clr = 1'b0;
    chk("t6_set_wins", ovf, 32'd1);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
